// File: rtl/jtframe_neptuno_joy_pkg.sv
// Shared types and constants for the Neptuno joystick serial transmitter.
package jtframe_neptuno_joy_pkg;

    localparam int FRAMEW_DEF = 16;

    // Button positions inside the 12-bit active-low joystick word
    localparam int BTN_U     = 0;
    localparam int BTN_D     = 1;
    localparam int BTN_L     = 2;
    localparam int BTN_R     = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_X     = 8;
    localparam int BTN_Y     = 9;
    localparam int BTN_Z     = 10;
    localparam int BTN_MODE  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Select low mimics the Mega Drive pad: L/R read as 0, start/A take C/B slots
    function automatic logic [7:0] player_byte(input logic [11:0] joy, input logic sel);
        logic [7:0] b;
        if (sel)
            b = {2'b11, joy[BTN_C], joy[BTN_B], joy[BTN_R], joy[BTN_L], joy[BTN_D], joy[BTN_U]};
        else
            b = {2'b11, joy[BTN_START], joy[BTN_A], 2'b00, joy[BTN_D], joy[BTN_U]};
        return b;
    endfunction

endpackage

// File: rtl/jtframe_sync.sv
// Multi-flop synchronizer for a small bundle of asynchronous level signals.
// Each bit is resampled independently; reset value is set per bit.
module jtframe_sync #(
    parameter int         W       = 3,
    parameter int         DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/jtframe_neptuno_joy_tx.sv
// Serialises two joystick states to a shift-register style initiator, MSB first.
// Output follows pin changes SYNCW+1 clk cycles later; load always overrides shifting.
module jtframe_neptuno_joy_tx
    import jtframe_neptuno_joy_pkg::*;
#(
    parameter int SYNCW  = 2,
    parameter int FRAMEW = FRAMEW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic        joy_select,
    input  logic [11:0] joy1,
    input  logic [11:0] joy2,
    output logic        joy_data,
    output logic        busy,
    output logic [7:0]  frames
);

    localparam int CNTW = $clog2(FRAMEW + 1);

    logic [2:0]        sync_q;
    logic              jclk_s, jld_s, jsel_s;
    logic              jclk_d;
    logic              jclk_rise;
    state_t            state, state_nxt;
    logic [FRAMEW-1:0] sr;
    logic [FRAMEW-1:0] load_word;
    logic [CNTW-1:0]   cnt;
    logic              cnt_full;

    jtframe_sync #(
        .W       (3),
        .DEPTH   (SYNCW),
        .RST_VAL (3'b110)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({joy_select, joy_load, joy_clk}),
        .dout  (sync_q)
    );

    assign jclk_s    = sync_q[0];
    assign jld_s     = sync_q[1];
    assign jsel_s    = sync_q[2];
    assign jclk_rise = jclk_s & ~jclk_d;
    assign cnt_full  = (cnt == CNTW'(FRAMEW));

    // Any frame length beyond the two player bytes is padded with idle-high bits
    always_comb begin
        load_word = '1;
        load_word[FRAMEW-1 -: 16] = {player_byte(joy1, jsel_s), player_byte(joy2, jsel_s)};
    end

    always_comb begin
        state_nxt = state;
        if (!jld_s) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    state_nxt = SHIFT;
                SHIFT:   if (cnt_full) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            jclk_d <= 1'b0;
            sr     <= '1;
            cnt    <= '0;
            frames <= '0;
        end else begin
            state  <= state_nxt;
            jclk_d <= jclk_s;
            if (!jld_s) begin
                sr <= load_word;
            end else if (state == LOAD) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                if (cnt_full)
                    frames <= frames + 8'd1;
                else if (jclk_rise) begin
                    sr  <= {sr[FRAMEW-2:0], 1'b1};
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign busy     = (state == LOAD) || (state == SHIFT);
    assign joy_data = busy ? sr[FRAMEW-1] : 1'b1;

endmodule

// File: tb/tb_jtframe_neptuno_joy_tx.sv
// Directed bench: drives the initiator side of the serial link and checks frames bit by bit.
module tb_jtframe_neptuno_joy_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        joy_clk = 1'b0;
    logic        joy_load = 1'b1;
    logic        joy_select = 1'b1;
    logic [11:0] joy1 = 12'hFFF;
    logic [11:0] joy2 = 12'hFFF;
    logic        joy_data;
    logic        busy;
    logic [7:0]  frames;

    int n_chk = 0;
    int n_err = 0;

    jtframe_neptuno_joy_tx #(.SYNCW(2), .FRAMEW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_select (joy_select),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy_data   (joy_data),
        .busy       (busy),
        .frames     (frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clk();
        joy_clk = 1'b1;
        idle(4);
        joy_clk = 1'b0;
        idle(4);
    endtask

    task automatic pulse_load();
        joy_load = 1'b0;
        idle(4);
        joy_load = 1'b1;
        idle(4);
    endtask

    // Samples joy_data then clocks the next bit out, n times
    task automatic read_bits(input int n, output logic [31:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            word = {word[30:0], joy_data};
            pulse_clk();
        end
    endtask

    logic [31:0] w;

    initial begin
        idle(2);
        chk("rst_data", 32'(joy_data), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Select high, U pressed on player 1; also measures load-to-busy latency
        joy1 = 12'hFFE; joy2 = 12'hFFF; joy_select = 1'b1;
        joy_load = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("lat_before", 32'(busy), 32'd0);
        @(posedge clk);
        #1 chk("lat_after", 32'(busy), 32'd1);
        idle(3);
        joy_load = 1'b1;
        idle(4);
        read_bits(16, w);
        chk("sel1_word", w, 32'h0000FEFF);
        chk("sel1_frames", 32'(frames), 32'd1);
        chk("sel1_busy", 32'(busy), 32'd0);

        // Select low: start and A pressed on player 1
        joy1 = 12'hF6F; joy2 = 12'hFFF; joy_select = 1'b0;
        idle(2);
        pulse_load();
        read_bits(16, w);
        chk("sel0_word", w, 32'h0000C3F3);
        chk("sel0_frames", 32'(frames), 32'd2);

        // Overrun: four extra clocks read idle-high and count one frame only
        joy1 = 12'hFFE; joy2 = 12'hFDF; joy_select = 1'b1;
        idle(2);
        pulse_load();
        read_bits(20, w);
        chk("ovr_word", w, 32'h000FEEFF);
        chk("ovr_frames", 32'(frames), 32'd3);
        chk("ovr_busy", 32'(busy), 32'd0);

        // Abort after five shifts, then a fresh frame with new buttons
        joy1 = 12'hFFF; joy2 = 12'hFFF;
        idle(2);
        pulse_load();
        read_bits(5, w);
        chk("abort_busy", 32'(busy), 32'd1);
        joy1 = 12'hFF7; joy2 = 12'hFFD;
        pulse_load();
        chk("abort_frames", 32'(frames), 32'd3);
        read_bits(16, w);
        chk("abort_word", w, 32'h0000F7FD);
        chk("abort_frames2", 32'(frames), 32'd4);

        // Race: clock rise and one-cycle load pulse together while shifting
        joy1 = 12'hFFF; joy2 = 12'hFFF;
        idle(2);
        pulse_load();
        joy1 = 12'hFFB; joy2 = 12'hFFE;
        joy_clk = 1'b1; joy_load = 1'b0;
        idle(1);
        joy_load = 1'b1;
        idle(4);
        chk("race_msb", 32'(joy_data), 32'd1);
        joy_clk = 1'b0;
        idle(4);
        read_bits(16, w);
        chk("race_word", w, 32'h0000FBFE);
        chk("race_frames", 32'(frames), 32'd5);

        // Asynchronous reset in the middle of a frame
        joy1 = 12'hFFE; joy2 = 12'hFFF;
        idle(2);
        pulse_load();
        read_bits(7, w);
        chk("mid_data", 32'(joy_data), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(joy_data), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frames", 32'(frames), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        pulse_load();
        read_bits(16, w);
        chk("post_word", w, 32'h0000FEFF);
        chk("post_frames", 32'(frames), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
